serial_rx_fifo: RTL and testbench

Receive buffer stage placed directly downstream of the asynchronous serial receiver. It captures each byte the receiver strobes out into a 16-entry FIFO and presents the oldest byte to the host-side register interface. It keeps line status (data available, overrun) and raises an interrupt on a programmable fill trigger or on an inter-packet idle timeout.

---
 rtl/serial_rx_fifo.sv | 118 +++++++++++
 tb/tb_serial_rx_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo
// Receive buffer behind the async serial receiver. Bytes strobed in on
// rx_ready go into a 2**AW-entry FIFO; the oldest byte is presented on
// dout (first-word-fall-through). Tracks line status and raises irq on a
// programmable fill level or on an idle timeout while data is held.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   rx_data/rx_ready: byte + one-clock write strobe from the receiver
//   rx_endofpacket  : one-clock idle pulse from the receiver
//   rd              : pop strobe (host data-register read)
//   lsr_rd          : line-status read strobe, clears overrun
//   flush           : FIFO clear
//   trig            : fill trigger select (1/4/8/14 entries)
//   dout            : head-of-FIFO byte
//   data_avail,count,full,overrun,timeout,irq : status
module serial_rx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  input  logic          rx_endofpacket,
  input  logic          rd,
  input  logic          lsr_rd,
  input  logic          flush,
  input  logic [1:0]    trig,
  output logic [7:0]    dout,
  output logic          data_avail,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overrun,
  output logic          timeout,
  output logic          irq
);
  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          do_wr, do_rd, empty;
  int            trig_level;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  always_comb begin
    // Flush overrides both sides. A write into a full FIFO is still taken
    // when the same-cycle read frees a slot.
    do_rd = rd && !empty && !flush;
    do_wr = rx_ready && (!full || do_rd) && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    // Overrun: a dropped byte sets it, and wins over a same-cycle lsr_rd.
    overrun_d = overrun_q;
    if (flush)                         overrun_d = 1'b0;
    else if (rx_ready && full && !rd)  overrun_d = 1'b1;
    else if (lsr_rd)                   overrun_d = 1'b0;

    // Timeout: clears win over a coincident end-of-packet.
    timeout_d = timeout_q;
    if (flush || rd || count_d == '0) timeout_d = 1'b0;
    else if (rx_endofpacket)          timeout_d = 1'b1;

    case (trig)
      2'b00:   trig_level = 1;
      2'b01:   trig_level = 4;
      2'b10:   trig_level = 8;
      default: trig_level = 14;
    endcase
    if (trig_level > DEPTH) trig_level = DEPTH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem_q[wr_ptr_q] <= rx_data;
  end

  assign dout       = mem_q[rd_ptr_q];
  assign data_avail = !empty;
  assign count      = count_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
  assign irq        = (int'(count_q) >= trig_level) | timeout_q;
endmodule

// File: tb/tb_serial_rx_fifo.sv
module tb_serial_rx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_ready = 1'b0, rx_endofpacket = 1'b0;
  logic       rd = 1'b0, lsr_rd = 1'b0, flush = 1'b0;
  logic [1:0] trig = 2'b00;
  logic [7:0] dout;
  logic       data_avail, full, overrun, timeout, irq;
  logic [4:0] count;

  int n_chk = 0, n_fail = 0;
  logic [7:0] sb[$];
  logic       ovr_m = 1'b0, to_m = 1'b0;
  logic [7:0] last_rd = '0;

  serial_rx_fifo #(.AW(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_endofpacket(rx_endofpacket), .rd(rd), .lsr_rd(lsr_rd),
    .flush(flush), .trig(trig), .dout(dout), .data_avail(data_avail),
    .count(count), .full(full), .overrun(overrun), .timeout(timeout),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lvl();
    case (trig)
      2'b00: return 1;
      2'b01: return 4;
      2'b10: return 8;
      default: return 14;
    endcase
  endfunction

  // Compare all status outputs against the model.
  task automatic chk_all();
    chk("count", 32'(count), 32'(sb.size()));
    chk("data_avail", 32'(data_avail), 32'(sb.size() != 0));
    chk("full", 32'(full), 32'(sb.size() == 16));
    chk("overrun", 32'(overrun), 32'(ovr_m));
    chk("timeout", 32'(timeout), 32'(to_m));
    chk("irq", 32'(irq), 32'((sb.size() >= lvl()) || to_m));
    if (sb.size() != 0) chk("dout_head", 32'(dout), 32'(sb[0]));
  endtask

  // One clock with the given strobes; model updated alongside.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic eop = 1'b0, input logic l = 1'b0,
                     input logic f = 1'b0);
    bit dor, dow;
    int n;
    n = sb.size();
    if (r && n > 0) chk("dout_rd", 32'(dout), 32'(sb[0]));
    if (f) begin
      sb.delete(); ovr_m = 1'b0; to_m = 1'b0;
    end else begin
      dor = r && n > 0;
      dow = w && (n < 16 || dor);
      if (w && n == 16 && !r) ovr_m = 1'b1;
      else if (l)             ovr_m = 1'b0;
      if (dor) last_rd = sb.pop_front();
      if (dow) sb.push_back(d);
      if (r || sb.size() == 0) to_m = 1'b0;
      else if (eop)            to_m = 1'b1;
    end
    rx_ready = w; rx_data = d; rd = r; rx_endofpacket = eop;
    lsr_rd = l; flush = f;
    @(posedge clk); #1;
    rx_ready = 0; rd = 0; rx_endofpacket = 0; lsr_rd = 0; flush = 0;
    chk_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rx_ready = 0;
    sb.delete(); ovr_m = 1'b0; to_m = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_avail", 32'(data_avail), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_to", 32'(timeout), 0);
    chk("rst_irq", 32'(irq), 0);
  endtask

  initial begin
    do_reset();

    // 1: basic write/read
    cyc(1, 8'h41, 0); cyc(1, 8'h42, 0); cyc(1, 8'h43, 0);
    chk("t1_count", 32'(count), 3);
    chk("t1_dout", 32'(dout), 32'h41);
    cyc(0, 0, 1); chk("t1_d42", 32'(dout), 32'h42);
    cyc(0, 0, 1); chk("t1_d43", 32'(dout), 32'h43);
    cyc(0, 0, 1);
    chk("t1_avail", 32'(data_avail), 0);
    cyc(0, 0, 1); // read while empty is ignored
    chk("t1_under", 32'(count), 0);

    // 2: fill, overrun, drain, lsr clear
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hAA, 0);
    chk("t2_full", 32'(full), 1);
    chk("t2_ovr", 32'(overrun), 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1);
      chk("t2_drain", 32'(last_rd), 32'(i));
    end
    cyc(0, 0, 0, 0, 1);
    chk("t2_ovr_clr", 32'(overrun), 0);

    // 3: full with simultaneous write+read, pointer wrap
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0);
    cyc(1, 8'h55, 1);
    chk("t3_count", 32'(count), 16);
    chk("t3_ovr", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);
    chk("t3_last", 32'(last_rd), 32'h55);

    // 4: fill triggers
    trig = 2'b01;
    for (int i = 0; i < 3; i++) cyc(1, 8'(i), 0);
    chk("t4_irq3", 32'(irq), 0);
    cyc(1, 8'h03, 0);
    chk("t4_irq4", 32'(irq), 1);
    cyc(0, 0, 1);
    chk("t4_irq_rd", 32'(irq), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    trig = 2'b11;
    for (int i = 0; i < 14; i++) begin
      cyc(1, 8'(i), 0);
      chk("t4_irq14", 32'(irq), 32'(i == 13));
    end
    for (int i = 0; i < 14; i++) cyc(0, 0, 1);

    // 5: idle timeout
    trig = 2'b10;
    cyc(1, 8'h61, 0); cyc(1, 8'h62, 0);
    chk("t5_irq_pre", 32'(irq), 0);
    cyc(0, 0, 0, 1);
    chk("t5_to", 32'(timeout), 1);
    chk("t5_irq", 32'(irq), 1);
    cyc(0, 0, 1, 1); // rd coincident with eop: clear wins
    chk("t5_to_clr", 32'(timeout), 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t5_to_empty", 32'(timeout), 0);
    cyc(1, 8'h70, 0, 1); // eop with same-cycle write into empty FIFO
    chk("t5_to_wr", 32'(timeout), 1);
    cyc(0, 0, 1);

    // 6: flush and mid-burst reset
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hEE, 0, 1);
    chk("t6_ovr", 32'(overrun), 1);
    cyc(1, 8'h99, 0, 0, 0, 1);
    chk("t6_count", 32'(count), 0);
    chk("t6_ovr_clr", 32'(overrun), 0);
    chk("t6_to_clr", 32'(timeout), 0);
    chk("t6_avail", 32'(data_avail), 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h80 + i), 0);
    rx_ready = 1'b1; rx_data = 8'hC3;
    do_reset();
    cyc(1, 8'h5A, 0);
    chk("t6_post_rst", 32'(dout), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
